// File: rtl/renode_irq_conditioner.sv
// Per-line interrupt conditioning: polarity correction, glitch filter, level/edge
// latching with missed-edge tracking, and a registered mask stage.
module renode_irq_conditioner #(
    parameter int                         InterruptsCount = 1,
    parameter int                         FilterCycles    = 2,
    parameter logic [InterruptsCount-1:0] EdgeMask        = '0,
    parameter logic [InterruptsCount-1:0] ActiveLowMask   = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [InterruptsCount-1:0] irq_sources,
    input  logic [InterruptsCount-1:0] irq_mask,
    input  logic [InterruptsCount-1:0] irq_clear,
    output logic [InterruptsCount-1:0] interrupts,
    output logic [InterruptsCount-1:0] pending,
    output logic [InterruptsCount-1:0] missed
);

    localparam int                    CntWidth = $clog2(FilterCycles + 1);
    localparam logic [CntWidth-1:0]   CntLast  = CntWidth'(FilterCycles);
    localparam logic [CntWidth-1:0]   CntOne   = CntWidth'(1);

    generate
        for (genvar gi = 0; gi < InterruptsCount; gi++) begin : g_line
            logic [CntWidth-1:0] cnt_reg;
            logic [CntWidth-1:0] cnt_next;
            logic                filt_reg;
            logic                filt_next;
            logic                filt_d_reg;
            logic                irq_reg;
            logic                src;
            logic                pend;

            assign src = irq_sources[gi] ^ ActiveLowMask[gi];

            // The count never exceeds FilterCycles: it commits and clears on that sample.
            always_comb begin
                cnt_next  = '0;
                filt_next = filt_reg;
                if (src != filt_reg) begin
                    if (cnt_reg + CntOne == CntLast) begin
                        filt_next = src;
                    end else begin
                        cnt_next = cnt_reg + CntOne;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg    <= '0;
                    filt_reg   <= 1'b0;
                    filt_d_reg <= 1'b0;
                    irq_reg    <= 1'b0;
                end else begin
                    cnt_reg    <= cnt_next;
                    filt_reg   <= filt_next;
                    filt_d_reg <= filt_reg;
                    irq_reg    <= pend & irq_mask[gi];
                end
            end

            if (EdgeMask[gi]) begin : g_edge
                logic pend_reg;
                logic missed_reg;
                logic rise;

                assign rise = filt_reg & ~filt_d_reg;

                // A rise landing together with a clear re-arms the latch but is not a miss.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        pend_reg   <= 1'b0;
                        missed_reg <= 1'b0;
                    end else begin
                        pend_reg   <= rise | (pend_reg & ~irq_clear[gi]);
                        missed_reg <= (rise & pend_reg & ~irq_clear[gi]) |
                                      (missed_reg & ~irq_clear[gi]);
                    end
                end

                assign pend       = pend_reg;
                assign missed[gi] = missed_reg;
            end else begin : g_level
                logic unused_clear;

                assign unused_clear = irq_clear[gi];
                assign pend         = filt_d_reg;
                assign missed[gi]   = 1'b0;
            end

            assign pending[gi]    = pend;
            assign interrupts[gi] = irq_reg;
        end
    endgenerate

endmodule

// File: tb/tb_renode_irq_conditioner.sv
// Directed bench: 4 lines, F=2, line 1 edge-latched, line 2 active-low.
module tb_renode_irq_conditioner;

    localparam int N = 4;
    localparam int F = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] irq_sources;
    logic [N-1:0] irq_mask;
    logic [N-1:0] irq_clear;
    logic [N-1:0] interrupts;
    logic [N-1:0] pending;
    logic [N-1:0] missed;

    int pass_cnt  = 0;
    int total_cnt = 0;

    renode_irq_conditioner #(
        .InterruptsCount(N),
        .FilterCycles   (F),
        .EdgeMask       (4'b0010),
        .ActiveLowMask  (4'b0100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_sources(irq_sources),
        .irq_mask   (irq_mask),
        .irq_clear  (irq_clear),
        .interrupts (interrupts),
        .pending    (pending),
        .missed     (missed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [N-1:0] src;
        logic [N-1:0] mask;
        logic [N-1:0] clr;
        logic [N-1:0] exp_int;
        logic [N-1:0] exp_pend;
        logic [N-1:0] exp_miss;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [N-1:0] ei,
                             input logic [N-1:0] ep, input logic [N-1:0] em);
        check({tag, ".interrupts"}, interrupts, ei);
        check({tag, ".pending"}, pending, ep);
        check({tag, ".missed"}, missed, em);
        $display("%s: int=%b pend=%b miss=%b", tag, interrupts, pending, missed);
    endtask

    initial begin
        // rst, src, mask, clr -> interrupts, pending, missed after the edge.
        // Line 2 source held 1 (deasserted) throughout the table.
        vecs[0]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[1]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[2]  = '{1'b0, 4'b1101, 4'b1111, 4'b0000, 4'b0000, 4'b1011, 4'b0000};
        vecs[3]  = '{1'b0, 4'b0100, 4'b1111, 4'b0000, 4'b1011, 4'b1011, 4'b0000};
        vecs[4]  = '{1'b0, 4'b0100, 4'b1111, 4'b0000, 4'b1011, 4'b1011, 4'b0000};
        vecs[5]  = '{1'b0, 4'b0110, 4'b1111, 4'b0000, 4'b1011, 4'b0010, 4'b0000};
        vecs[6]  = '{1'b0, 4'b0110, 4'b1111, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
        vecs[7]  = '{1'b0, 4'b0100, 4'b1111, 4'b0000, 4'b0010, 4'b0010, 4'b0010};
        vecs[8]  = '{1'b0, 4'b1101, 4'b1111, 4'b0000, 4'b0010, 4'b0010, 4'b0010};
        vecs[9]  = '{1'b0, 4'b0100, 4'b1111, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        vecs[10] = '{1'b0, 4'b0100, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[11] = '{1'b0, 4'b0110, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[12] = '{1'b0, 4'b0110, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[13] = '{1'b0, 4'b0100, 4'b1101, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
        vecs[14] = '{1'b0, 4'b0100, 4'b1101, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
        vecs[15] = '{1'b0, 4'b0100, 4'b1111, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
        vecs[16] = '{1'b0, 4'b0110, 4'b1111, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
        vecs[17] = '{1'b0, 4'b0110, 4'b1111, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
        vecs[18] = '{1'b0, 4'b0100, 4'b1111, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
        vecs[19] = '{1'b0, 4'b0100, 4'b1111, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
        vecs[20] = '{1'b1, 4'b0100, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[21] = '{1'b0, 4'b0100, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

        rst         = 1'b1;
        irq_sources = 4'b0100;
        irq_mask    = 4'b1111;
        irq_clear   = 4'b0000;
        step();
        step();
        check_all("reset", 4'b0000, 4'b0000, 4'b0000);

        for (int i = 0; i < 22; i++) begin
            rst         = vecs[i].rst;
            irq_sources = vecs[i].src;
            irq_mask    = vecs[i].mask;
            irq_clear   = vecs[i].clr;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].exp_int, vecs[i].exp_pend, vecs[i].exp_miss);
        end

        // Active-low line 2 held asserted across reset.
        irq_sources = 4'b0000;
        irq_mask    = 4'b1111;
        irq_clear   = 4'b0000;
        rst         = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_all($sformatf("al_rst%0d", i), 4'b0000, 4'b0000, 4'b0000);
        end
        rst = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            logic [N-1:0] ei;
            logic [N-1:0] ep;
            step();
            ei = (n >= F + 2) ? 4'b0100 : 4'b0000;
            ep = (n >= F + 1) ? 4'b0100 : 4'b0000;
            check_all($sformatf("al_post%0d", n), ei, ep, 4'b0000);
        end

        // Reset while line 0 is part-way through its filter count.
        irq_sources = 4'b0101;
        step();
        check_all("mid_pre", 4'b0100, 4'b0100, 4'b0000);
        rst = 1'b1;
        step();
        check_all("mid_rst", 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            logic [N-1:0] ei;
            logic [N-1:0] ep;
            step();
            ei = (n >= F + 2) ? 4'b0001 : 4'b0000;
            ep = (n >= F + 1) ? 4'b0001 : 4'b0000;
            check_all($sformatf("mid_post%0d", n), ei, ep, 4'b0000);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
